pipe_stage_reg: RTL

- Parametrised pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
- Next-generation replacement for plain enable/reset stage registers in the pipelined CPU datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Supports back-pressure without a combinational ready path and a synchronous flush for branch/exception squash.
- Sustains one transfer per cycle with 1-cycle latency.

---
 rtl/pipe_stage_reg_pkg.sv | 18 +
 rtl/pipe_stage_reg_data.sv | 28 ++
 rtl/pipe_stage_reg.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the pipeline stage register.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   pipe_state_t : occupancy of the stage (EMPTY, ONE = main full, TWO = main + skid full)
//   PIPE_DEPTH   : number of payload slots held by one stage
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int unsigned PIPE_DEPTH = 2;

endpackage

// File: rtl/pipe_stage_reg_data.sv
// Payload register with load enable and synchronous reset to a fixed value.
// Latency: 1 cycle from d/en to q.
// Backpressure: none; holds its value whenever en is low.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset (loads RESET_VAL)
//   en         : load d on the next rising edge
//   d, q       : WIDTH-bit payload in / registered payload out
module pipe_data_reg #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Latency: 1 cycle when empty; full throughput of one transfer per cycle.
// Backpressure: in_ready comes from registered occupancy only; the skid slot absorbs the
//   one beat that arrives while downstream stalls, so out_ready never reaches in_ready.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset (priority over flush)
//   flush                : squash all held entries; an accepted input this cycle is discarded
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload (main register)
//   stall_cnt            : saturating count of cycles upstream was blocked
//                          (only when PIPE_STAGE_STATS_EN is defined)
//
// Build option: define PIPE_STAGE_STATS_EN to add the stall_cnt port and counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1 || PIPE_DEPTH != 2) begin : g_param_check
    $error("pipe_stage_reg: WIDTH and CNT_W must be >= 1");
  end

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             main_from_skid;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Both handshake outputs depend only on state (and reset for in_ready).
  assign in_ready  = (state_q != TWO) & ~reset;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain case exists.
        if (out_fire) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Squash: any accepted input is dropped and the data registers are left alone,
    // since their contents are meaningless once the stage is empty.
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_data_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_main_reg (
    .clk  (clk),
    .reset(reset),
    .en   (main_en),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_data_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_skid_reg (
    .clk  (clk),
    .reset(reset),
    .en   (skid_en),
    .d    (in_data),
    .q    (skid_q)
  );

`ifdef PIPE_STAGE_STATS_EN
  // Counts cycles where upstream offers data but the stage is full; not cleared by flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
